// File: rtl/d8m_pattern_tx.sv
`timescale 1ns/1ps
// D8M parallel pixel bus emulator: 10-bit Bayer test frames with FVAL/LVAL framing.
// The FSM position (state, x, y) is registered; every output is registered from it one edge later.
module d8m_pattern_tx #(
   parameter int H_ACTIVE = 640,
   parameter int H_BLANK  = 160,
   parameter int V_ACTIVE = 480,
   parameter int V_PRE    = 2,
   parameter int V_POST   = 2,
   parameter int V_GAP    = 10
) (
   input  logic        iCLK,
   input  logic        iRST_N,
   input  logic        iEN,
   input  logic [1:0]  iMODE,
   input  logic [9:0]  iSOLID_R,
   input  logic [9:0]  iSOLID_G,
   input  logic [9:0]  iSOLID_B,
   output logic [9:0]  oPIXEL_D,
   output logic        oPIXEL_HS,
   output logic        oPIXEL_VS,
   output logic [15:0] oFRAME_CNT,
   output logic        oBUSY
);

   localparam int H_TOTAL = H_ACTIVE + H_BLANK;
   localparam int BAR_W   = H_ACTIVE / 8;

   typedef enum logic [2:0] {S_IDLE, S_PRE, S_ACTIVE, S_POST, S_GAP} state_t;

   state_t      state_reg;
   logic [15:0] x_reg;
   logic [15:0] y_reg;
   logic [15:0] bar_cnt_reg;
   logic [2:0]  bar_idx_reg;
   logic [1:0]  mode_reg;
   logic [9:0]  solid_r_reg;
   logic [9:0]  solid_g_reg;
   logic [9:0]  solid_b_reg;
   logic [15:0] frame_cnt_reg;

   logic [15:0] line_last;
   logic        in_active;
   logic        site_r;
   logic        site_g;
   logic        site_b;
   logic        bar_bit;
   logic [9:0]  pix_next;

   assign oFRAME_CNT = frame_cnt_reg;

   always_comb begin
      line_last = 16'(V_PRE - 1);
      case (state_reg)
         S_ACTIVE: line_last = 16'(V_ACTIVE - 1);
         S_POST:   line_last = 16'(V_POST - 1);
         S_GAP:    line_last = 16'(V_GAP - 1);
         default:  line_last = 16'(V_PRE - 1);
      endcase
   end

   // Bayer site of the current pixel: even rows G/R, odd rows B/G.
   always_comb begin
      in_active = (state_reg == S_ACTIVE) && (x_reg < 16'(H_ACTIVE));
      site_r    = ~y_reg[0] & x_reg[0];
      site_b    = y_reg[0] & ~x_reg[0];
      site_g    = ~(site_r | site_b);
      bar_bit   = site_r ? bar_idx_reg[2] : (site_g ? bar_idx_reg[1] : bar_idx_reg[0]);
      case (mode_reg)
         2'd0:    pix_next = {10{bar_bit}};
         2'd1:    pix_next = x_reg[9:0] + y_reg[9:0];
         2'd2:    pix_next = site_r ? solid_r_reg : (site_g ? solid_g_reg : solid_b_reg);
         default: pix_next = {10{x_reg[3] ^ y_reg[3]}};
      endcase
   end

   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         state_reg     <= S_IDLE;
         x_reg         <= '0;
         y_reg         <= '0;
         bar_cnt_reg   <= '0;
         bar_idx_reg   <= '0;
         mode_reg      <= '0;
         solid_r_reg   <= '0;
         solid_g_reg   <= '0;
         solid_b_reg   <= '0;
         frame_cnt_reg <= '0;
         oPIXEL_D      <= '0;
         oPIXEL_HS     <= 1'b0;
         oPIXEL_VS     <= 1'b0;
         oBUSY         <= 1'b0;
      end else begin
         oPIXEL_VS <= (state_reg == S_PRE) || (state_reg == S_ACTIVE) || (state_reg == S_POST);
         oPIXEL_HS <= in_active;
         oPIXEL_D  <= in_active ? pix_next : 10'd0;
         // First gap position: VS falls on this edge, so the frame is complete.
         if (state_reg == S_GAP && x_reg == 16'd0 && y_reg == 16'd0)
            frame_cnt_reg <= frame_cnt_reg + 16'd1;

         if (state_reg == S_IDLE) begin
            if (iEN) begin
               state_reg   <= S_PRE;
               oBUSY       <= 1'b1;
               mode_reg    <= iMODE;
               solid_r_reg <= iSOLID_R;
               solid_g_reg <= iSOLID_G;
               solid_b_reg <= iSOLID_B;
            end
         end else if (x_reg == 16'(H_TOTAL - 1)) begin
            x_reg       <= '0;
            bar_cnt_reg <= '0;
            bar_idx_reg <= '0;
            if (y_reg != line_last) begin
               y_reg <= y_reg + 16'd1;
            end else begin
               y_reg <= '0;
               case (state_reg)
                  S_PRE:    state_reg <= S_ACTIVE;
                  S_ACTIVE: state_reg <= S_POST;
                  S_POST:   state_reg <= S_GAP;
                  default: begin
                     if (iEN) begin
                        state_reg   <= S_PRE;
                        mode_reg    <= iMODE;
                        solid_r_reg <= iSOLID_R;
                        solid_g_reg <= iSOLID_G;
                        solid_b_reg <= iSOLID_B;
                     end else begin
                        state_reg <= S_IDLE;
                        oBUSY     <= 1'b0;
                     end
                  end
               endcase
            end
         end else begin
            x_reg <= x_reg + 16'd1;
            // Bar index steps every H_ACTIVE/8 pixels without a divider.
            if (in_active) begin
               if (bar_cnt_reg == 16'(BAR_W - 1)) begin
                  bar_cnt_reg <= '0;
                  bar_idx_reg <= bar_idx_reg + 3'd1;
               end else begin
                  bar_cnt_reg <= bar_cnt_reg + 16'd1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_d8m_pattern_tx.sv
`timescale 1ns/1ps
// Self-checking bench for d8m_pattern_tx: every output cycle of each frame and gap is
// compared with a frame/line/pixel model built from division and modulo arithmetic.
module tb_d8m_pattern_tx;

   localparam int H_ACTIVE = 16;
   localparam int H_BLANK  = 4;
   localparam int V_ACTIVE = 4;
   localparam int V_PRE    = 1;
   localparam int V_POST   = 1;
   localparam int V_GAP    = 2;
   localparam int HT       = H_ACTIVE + H_BLANK;
   localparam int VS_LEN   = (V_PRE + V_ACTIVE + V_POST) * HT;
   localparam int GAP_LEN  = V_GAP * HT;

   logic        iCLK;
   logic        iRST_N;
   logic        iEN;
   logic [1:0]  iMODE;
   logic [9:0]  iSOLID_R;
   logic [9:0]  iSOLID_G;
   logic [9:0]  iSOLID_B;
   logic [9:0]  oPIXEL_D;
   logic        oPIXEL_HS;
   logic        oPIXEL_VS;
   logic [15:0] oFRAME_CNT;
   logic        oBUSY;

   int tests_run    = 0;
   int tests_failed = 0;

   logic [1:0]  exp_mode, nxt_mode;
   logic [9:0]  exp_r, exp_g, exp_b, nxt_r, nxt_g, nxt_b;
   logic        nxt_en;
   logic [15:0] exp_cnt;

   d8m_pattern_tx #(
      .H_ACTIVE(H_ACTIVE), .H_BLANK(H_BLANK), .V_ACTIVE(V_ACTIVE),
      .V_PRE(V_PRE), .V_POST(V_POST), .V_GAP(V_GAP)
   ) dut (
      .iCLK(iCLK), .iRST_N(iRST_N), .iEN(iEN), .iMODE(iMODE),
      .iSOLID_R(iSOLID_R), .iSOLID_G(iSOLID_G), .iSOLID_B(iSOLID_B),
      .oPIXEL_D(oPIXEL_D), .oPIXEL_HS(oPIXEL_HS), .oPIXEL_VS(oPIXEL_VS),
      .oFRAME_CNT(oFRAME_CNT), .oBUSY(oBUSY)
   );

   initial iCLK = 1'b0;
   always #5 iCLK = ~iCLK;

   function automatic logic [9:0] exp_pix(input logic [1:0] m, input logic [9:0] r, input logic [9:0] g,
                                          input logic [9:0] b, input int px, input int ly);
      bit is_r, is_b, is_g, on;
      int bar;
      is_r = (ly % 2 == 0) && (px % 2 == 1);
      is_b = (ly % 2 == 1) && (px % 2 == 0);
      is_g = !is_r && !is_b;
      bar  = px / (H_ACTIVE / 8);
      case (m)
         2'd0: begin
            on = is_r ? (bar >= 4) : (is_g ? ((bar / 2) % 2 == 1) : (bar % 2 == 1));
            return on ? 10'h3FF : 10'h000;
         end
         2'd1: return 10'((px + ly) % 1024);
         2'd2: return is_r ? r : (is_g ? g : b);
         default: return (((px / 8) % 2) != ((ly / 8) % 2)) ? 10'h3FF : 10'h000;
      endcase
   endfunction

   task automatic check_idle(input string tag);
      tests_run++;
      if ({oPIXEL_VS, oPIXEL_HS, oBUSY, oPIXEL_D, oFRAME_CNT} !== {1'b0, 1'b0, 1'b0, 10'd0, exp_cnt}) begin
         tests_failed++;
         $display("FAIL %s: got vs=%b hs=%b busy=%b d=%h cnt=%h, expected vs=0 hs=0 busy=0 d=000 cnt=%h",
                  tag, oPIXEL_VS, oPIXEL_HS, oBUSY, oPIXEL_D, oFRAME_CNT, exp_cnt);
      end
   endtask

   // Called at a negedge with the DUT idle; returns on the negedge where VS should first be high.
   task automatic start_frame();
      iMODE = exp_mode; iSOLID_R = exp_r; iSOLID_G = exp_g; iSOLID_B = exp_b;
      iEN = 1'b1;
      @(negedge iCLK);
      tests_run++;
      if (oPIXEL_VS !== 1'b0 || oBUSY !== 1'b1) begin
         tests_failed++;
         $display("FAIL start_latency: got vs=%b busy=%b, expected vs=0 busy=1", oPIXEL_VS, oBUSY);
      end
      @(negedge iCLK);
   endtask

   // Checks one frame from its first VS-high cycle, then its gap; stop_at >= 0 returns early.
   task automatic run_frame(input bit scramble, input int stop_at);
      int ln, px, ly;
      bit act;
      logic [9:0] e_d;
      logic e_busy;
      for (int c = 0; c < VS_LEN; c++) begin
         ln  = c / HT;
         px  = c % HT;
         ly  = ln - V_PRE;
         act = (ln >= V_PRE) && (ln < V_PRE + V_ACTIVE) && (px < H_ACTIVE);
         e_d = act ? exp_pix(exp_mode, exp_r, exp_g, exp_b, px, ly) : 10'd0;
         tests_run++;
         if ({oPIXEL_VS, oPIXEL_HS, oBUSY, oPIXEL_D, oFRAME_CNT} !== {1'b1, act, 1'b1, e_d, exp_cnt}) begin
            tests_failed++;
            $display("FAIL frame_cycle c=%0d mode=%0d: got vs=%b hs=%b busy=%b d=%h cnt=%h, expected vs=1 hs=%b busy=1 d=%h cnt=%h",
                     c, exp_mode, oPIXEL_VS, oPIXEL_HS, oBUSY, oPIXEL_D, oFRAME_CNT, act, e_d, exp_cnt);
         end
         if (c == stop_at) return;
         if (scramble && c == VS_LEN / 2) begin
            iMODE = 2'($urandom); iSOLID_R = 10'($urandom); iSOLID_G = 10'($urandom);
            iSOLID_B = 10'($urandom); iEN = 1'($urandom);
         end
         @(negedge iCLK);
      end
      exp_cnt = exp_cnt + 16'd1;
      for (int g = 0; g < GAP_LEN; g++) begin
         e_busy = (g == GAP_LEN - 1) ? nxt_en : 1'b1;
         tests_run++;
         if ({oPIXEL_VS, oPIXEL_HS, oBUSY, oPIXEL_D, oFRAME_CNT} !== {1'b0, 1'b0, e_busy, 10'd0, exp_cnt}) begin
            tests_failed++;
            $display("FAIL gap_cycle g=%0d: got vs=%b hs=%b busy=%b d=%h cnt=%h, expected vs=0 hs=0 busy=%b d=000 cnt=%h",
                     g, oPIXEL_VS, oPIXEL_HS, oBUSY, oPIXEL_D, oFRAME_CNT, e_busy, exp_cnt);
         end
         if (g == 0) begin
            iMODE = nxt_mode; iSOLID_R = nxt_r; iSOLID_G = nxt_g; iSOLID_B = nxt_b; iEN = nxt_en;
         end
         @(negedge iCLK);
      end
      tests_run++;
      if (oPIXEL_VS !== nxt_en || oBUSY !== nxt_en) begin
         tests_failed++;
         $display("FAIL frame_restart: got vs=%b busy=%b, expected vs=%b busy=%b", oPIXEL_VS, oBUSY, nxt_en, nxt_en);
      end
      $display("[TB] frame mode=%0d done, frame_cnt now %h, next %s", exp_mode, exp_cnt, nxt_en ? "frame" : "idle");
      if (nxt_en) begin
         exp_mode = nxt_mode; exp_r = nxt_r; exp_g = nxt_g; exp_b = nxt_b;
      end
   endtask

   task automatic set_next_random(input bit en);
      nxt_mode = 2'($urandom); nxt_r = 10'($urandom); nxt_g = 10'($urandom); nxt_b = 10'($urandom);
      nxt_en = en;
   endtask

   task automatic test_reset();
      iRST_N = 1'b0; iEN = 1'b0; iMODE = '0; iSOLID_R = '0; iSOLID_G = '0; iSOLID_B = '0;
      exp_cnt = 16'd0;
      repeat (3) @(negedge iCLK);
      check_idle("reset_state");
      iRST_N = 1'b1;
      repeat (4) @(negedge iCLK);
      check_idle("idle_without_enable");
   endtask

   task automatic test_colour_bars();
      exp_mode = 2'd0; exp_r = '0; exp_g = '0; exp_b = '0;
      start_frame();
      nxt_mode = 2'd0; nxt_r = '0; nxt_g = '0; nxt_b = '0; nxt_en = 1'b1;
      run_frame(1'b0, -1);
      nxt_mode = 2'd2; nxt_r = 10'h155; nxt_g = 10'h0AA; nxt_b = 10'h3C0; nxt_en = 1'b1;
      run_frame(1'b0, -1);
   endtask

   task automatic test_solid();
      set_next_random(1'b1);
      nxt_mode = 2'd2;
      run_frame(1'b0, -1);
      set_next_random(1'b1);
      run_frame(1'b0, -1);
   endtask

   task automatic test_random_modes();
      for (int i = 0; i < 4; i++) begin
         set_next_random(1'b1);
         run_frame(1'b1, -1);
      end
   endtask

   task automatic test_latch();
      set_next_random(1'b1);
      nxt_mode = 2'd2;
      run_frame(1'b1, -1);
      set_next_random(1'b1);
      nxt_mode = 2'd1;
      run_frame(1'b1, -1);
      set_next_random(1'b0);
      run_frame(1'b1, -1);
      iEN = 1'b0;
      repeat (5) @(negedge iCLK);
      check_idle("idle_after_enable_drop");
   endtask

   task automatic test_reset_mid();
      exp_mode = 2'($urandom); exp_r = 10'($urandom); exp_g = 10'($urandom); exp_b = 10'($urandom);
      start_frame();
      run_frame(1'b0, (V_PRE + 2) * HT + 7);
      #2 iRST_N = 1'b0;
      #1 exp_cnt = 16'd0;
      check_idle("async_reset_mid_active");
      @(negedge iCLK);
      iRST_N = 1'b1;
      start_frame();
      set_next_random(1'b0);
      run_frame(1'b0, -1);
   endtask

   task automatic test_wrap();
      force dut.frame_cnt_reg = 16'hFFFF;
      #1 release dut.frame_cnt_reg;
      exp_cnt = 16'hFFFF;
      check_idle("preload_ffff");
      @(negedge iCLK);
      exp_mode = 2'd3;
      start_frame();
      set_next_random(1'b0);
      run_frame(1'b0, -1);
      tests_run++;
      if (oFRAME_CNT !== 16'h0000) begin
         tests_failed++;
         $display("FAIL frame_cnt_wrap: got %h, expected 0000", oFRAME_CNT);
      end
   endtask

   initial begin
      test_reset();
      test_colour_bars();
      test_solid();
      test_random_modes();
      test_latch();
      test_reset_mid();
      test_wrap();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
